fifo_sync_flex: RTL and testbench

Parametrised single-clock FIFO, successor to the original fixed 32x512 buffer.
- Generalises data width and depth; correct full/empty under simultaneous push/pop.
- Adds programmable almost-full/almost-empty flags, occupancy count, synchronous flush, sticky overflow/underflow errors, and a selectable read mode (registered or first-word-fall-through).
- Sits between producer/consumer stages on the same clock as a general buffering primitive.

---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_mem_2p.sv | 26 ++
 rtl/fifo_sync_flex.sv | 116 +++++++++++
 tb/tb_fifo_sync_flex.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the fifo_sync_flex buffer.
// Read-mode enum, count-width helper and configuration legality check.
package fifo_pkg;

    typedef enum logic {
        RD_REG  = 1'b0,
        RD_FWFT = 1'b1
    } rd_mode_e;

    // Occupancy needs one bit more than a pointer to represent DEPTH itself.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic bit cfg_ok(input int depth, input int ae, input int af);
        return (depth >= 4) && ((depth & (depth - 1)) == 0)
            && (ae < af) && (af <= depth);
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// DW x DEPTH storage: one synchronous write port, one asynchronous read port.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read). Contents not reset.
module fifo_mem_2p #(
    parameter int DW    = 32,
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_flex.sv
// Parametrised single-clock FIFO with flags, count, flush and sticky errors.
// Ports: clk, rst (async, active-low), push/din, pop/dout, flush,
//        full, empty, almost_full, almost_empty, count, overflow, underflow.
module fifo_sync_flex
    import fifo_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 512,
    parameter int AW    = $clog2(DEPTH),
    parameter int AF_TH = DEPTH - 4,
    parameter int AE_TH = 4,
    parameter int FWFT  = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    input  logic          flush,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          underflow
);

    localparam int       CW   = AW + 1;
    localparam rd_mode_e MODE = (FWFT != 0) ? RD_FWFT : RD_REG;

    if (!cfg_ok(DEPTH, AE_TH, AF_TH) || (cnt_w(DEPTH) != CW)) begin : g_bad_cfg
        $error("fifo_sync_flex: illegal DEPTH/AW/threshold configuration");
    end

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [DW-1:0] rdata;
    logic          wr_en;
    logic          rd_en;

    // Accepts look only at pre-edge flags; full/empty never look ahead.
    assign wr_en = push & ~full  & ~flush;
    assign rd_en = pop  & ~empty & ~flush;

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AF_TH));
    assign almost_empty = (count <= CW'(AE_TH));

    fifo_mem_2p #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (din),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && !rd_en) begin
                count <= count + 1'b1;
            end else if (rd_en && !wr_en) begin
                count <= count - 1'b1;
            end
            if (push && full) begin
                overflow <= 1'b1;
            end
            if (pop && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    if (MODE == RD_FWFT) begin : g_fwft
        // Head word shown directly; forced to zero so an empty FIFO reads 0.
        assign dout = empty ? '0 : rdata;
    end else begin : g_reg
        logic [DW-1:0] dout_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                dout_q <= '0;
            end else if (rd_en) begin
                dout_q <= rdata;
            end
        end

        assign dout = dout_q;
    end

endmodule

// File: tb/tb_fifo_sync_flex.sv
// Directed self-checking bench for fifo_sync_flex.
// Instance u0: FWFT=0, 32x512. Instance u1: FWFT=1, 8x16.
module tb_fifo_sync_flex;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0 = 1'b0;
    logic        push0 = 1'b0;
    logic        pop0 = 1'b0;
    logic        flush0 = 1'b0;
    logic [31:0] din0 = '0;
    logic [31:0] dout0;
    logic        full0, empty0, af0, ae0, ovf0, unf0;
    logic [9:0]  count0;

    logic        rst1 = 1'b0;
    logic        push1 = 1'b0;
    logic        pop1 = 1'b0;
    logic        flush1 = 1'b0;
    logic [7:0]  din1 = '0;
    logic [7:0]  dout1;
    logic        full1, empty1, af1, ae1, ovf1, unf1;
    logic [4:0]  count1;

    int n_chk = 0;
    int n_err = 0;

    fifo_sync_flex #(
        .DW    (32),
        .DEPTH (512),
        .FWFT  (0)
    ) u0 (
        .clk          (clk),
        .rst          (rst0),
        .push         (push0),
        .din          (din0),
        .pop          (pop0),
        .flush        (flush0),
        .dout         (dout0),
        .full         (full0),
        .empty        (empty0),
        .almost_full  (af0),
        .almost_empty (ae0),
        .count        (count0),
        .overflow     (ovf0),
        .underflow    (unf0)
    );

    fifo_sync_flex #(
        .DW    (8),
        .DEPTH (16),
        .FWFT  (1)
    ) u1 (
        .clk          (clk),
        .rst          (rst1),
        .push         (push1),
        .din          (din1),
        .pop          (pop1),
        .flush        (flush1),
        .dout         (dout1),
        .full         (full1),
        .empty        (empty1),
        .almost_full  (af1),
        .almost_empty (ae1),
        .count        (count1),
        .overflow     (ovf1),
        .underflow    (unf1)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_count", 64'(count0), 64'd0);
        chk("rst_empty", 64'(empty0), 64'd1);
        chk("rst_full", 64'(full0), 64'd0);
        chk("rst_ae", 64'(ae0), 64'd1);
        chk("rst_af", 64'(af0), 64'd0);
        chk("rst_dout", 64'(dout0), 64'd0);
        chk("rst_ovf", 64'(ovf0), 64'd0);
        chk("rst_unf", 64'(unf0), 64'd0);
        chk("rst1_dout", 64'(dout1), 64'd0);
        rst0 = 1'b1;
        rst1 = 1'b1;

        // Fill 0..511
        push0 = 1'b1;
        for (int i = 0; i < 512; i++) begin
            din0 = 32'(i);
            tick();
            chk("fill_count", 64'(count0), 64'(i + 1));
            chk("fill_af", 64'(af0), 64'((i + 1) >= 508));
            chk("fill_full", 64'(full0), 64'((i + 1) == 512));
        end
        din0 = 32'hDEAD;
        tick();
        chk("ovf_set", 64'(ovf0), 64'd1);
        chk("ovf_count", 64'(count0), 64'd512);
        push0 = 1'b0;

        // Drain in order
        pop0 = 1'b1;
        for (int i = 0; i < 512; i++) begin
            tick();
            chk("drain_dout", 64'(dout0), 64'(i));
        end
        chk("drain_empty", 64'(empty0), 64'd1);
        tick();
        chk("unf_set", 64'(unf0), 64'd1);
        chk("unf_count", 64'(count0), 64'd0);
        chk("unf_dout", 64'(dout0), 64'd511);
        pop0 = 1'b0;

        // Steady push/pop at count=3 across pointer wrap
        push0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din0 = 32'(1000 + i);
            tick();
        end
        pop0 = 1'b1;
        for (int k = 0; k < 600; k++) begin
            din0 = 32'(1003 + k);
            tick();
            chk("pp_dout", 64'(dout0), 64'(1000 + k));
            chk("pp_count", 64'(count0), 64'd3);
        end
        push0 = 1'b0;
        pop0 = 1'b0;

        // Boundaries
        flush0 = 1'b1;
        tick();
        flush0 = 1'b0;
        chk("fl_count", 64'(count0), 64'd0);
        chk("fl_unf", 64'(unf0), 64'd0);
        push0 = 1'b1;
        pop0 = 1'b1;
        din0 = 32'h100;
        tick();
        chk("b0_count", 64'(count0), 64'd1);
        chk("b0_unf", 64'(unf0), 64'd1);
        chk("b0_ovf", 64'(ovf0), 64'd0);
        pop0 = 1'b0;
        for (int i = 1; i < 512; i++) begin
            din0 = 32'(32'h100 + i);
            tick();
        end
        chk("b1_full", 64'(full0), 64'd1);
        pop0 = 1'b1;
        din0 = 32'hBEEF;
        tick();
        chk("b1_count", 64'(count0), 64'd511);
        chk("b1_ovf", 64'(ovf0), 64'd1);
        chk("b1_dout", 64'(dout0), 64'h100);
        push0 = 1'b0;

        // Flush at count=100 with push and pop high
        for (int i = 0; i < 411; i++) begin
            tick();
        end
        chk("pf_dout", 64'(dout0), 64'h29B);
        chk("pf_count", 64'(count0), 64'd100);
        flush0 = 1'b1;
        push0 = 1'b1;
        din0 = 32'h1234;
        tick();
        flush0 = 1'b0;
        push0 = 1'b0;
        pop0 = 1'b0;
        chk("f_count", 64'(count0), 64'd0);
        chk("f_empty", 64'(empty0), 64'd1);
        chk("f_ovf", 64'(ovf0), 64'd0);
        chk("f_unf", 64'(unf0), 64'd0);
        chk("f_dout", 64'(dout0), 64'h29B);
        push0 = 1'b1;
        din0 = 32'hA5;
        tick();
        din0 = 32'h5A;
        tick();
        push0 = 1'b0;
        pop0 = 1'b1;
        tick();
        pop0 = 1'b0;
        chk("f_head", 64'(dout0), 64'hA5);

        // FWFT instance
        push1 = 1'b1;
        din1 = 8'h11;
        tick();
        push1 = 1'b0;
        chk("fw_dout", 64'(dout1), 64'h11);
        chk("fw_count", 64'(count1), 64'd1);
        push1 = 1'b1;
        din1 = 8'h22;
        tick();
        din1 = 8'h33;
        tick();
        push1 = 1'b0;
        pop1 = 1'b1;
        tick();
        pop1 = 1'b0;
        chk("fw_pop", 64'(dout1), 64'h22);
        chk("fw_cnt2", 64'(count1), 64'd2);
        push1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din1 = 8'(8'h40 + i);
            tick();
        end
        #2;
        rst1 = 1'b0;
        #1;
        chk("ar_empty", 64'(empty1), 64'd1);
        chk("ar_dout", 64'(dout1), 64'd0);
        chk("ar_count", 64'(count1), 64'd0);
        tick();
        rst1 = 1'b1;
        din1 = 8'h77;
        tick();
        push1 = 1'b0;
        chk("ar_head", 64'(dout1), 64'h77);
        chk("ar_cnt1", 64'(count1), 64'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
